// File: rtl/note_fold_smoother.sv
// -----------------------------------------------------------------------------
// note_fold_smoother
//
// Collects one frame of per-octave DFT bin amplitudes (BIN_QTY*OCTAVES bins,
// note-major within each octave) from a valid/ready stream. It folds the
// octaves into BIN_QTY note sums, clamps each sum to the W.D unsigned range and
// presents the note array with a one-cycle start pulse. The output array is
// held stable until the next frame's pulse.
//
// Optional feature macro: NOTE_FOLD_IIR_EN
//   defined   : per-note first-order IIR, y += (sat - y) >>> IIR_SHIFT, whose
//               state persists across frames (cleared only by reset)
//   undefined : outputs are the clamped folded sums of the current frame;
//               no IIR state is built and IIR_SHIFT has no effect
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active low
//   bin_i            in   bin amplitude, unsigned W.D fixed point
//   bin_v_i          in   bin_i valid
//   bin_ready_o      out  a bin is accepted on any edge with bin_v_i=1 here
//   noteAmplitudes_o out  BIN_QTY note amplitudes, W.D, updated at EMIT only
//   start_o          out  one-cycle pulse: new noteAmplitudes_o available
//   frame_sat_o      out  some note clamped this frame (valid with start_o)
//   busy_o           out  high while filtering / emitting
// -----------------------------------------------------------------------------
module note_fold_smoother #(
    parameter int W         = 5,
    parameter int D         = 11,
    parameter int BIN_QTY   = 12,
    parameter int OCTAVES   = 5,
    parameter int IIR_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W+D-1:0]              bin_i,
    input  logic                        bin_v_i,
    output logic                        bin_ready_o,
    output logic [BIN_QTY-1:0][W+D-1:0] noteAmplitudes_o,
    output logic                        start_o,
    output logic                        frame_sat_o,
    output logic                        busy_o
);
    localparam int AW     = W + D;
    // Room for OCTAVES full-scale additions, so the fold itself never wraps.
    localparam int ACC_W  = AW + $clog2(OCTAVES);
    localparam int NOTE_W = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int OCT_W  = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;

    localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(BIN_QTY - 1);
    localparam logic [OCT_W-1:0]  LAST_OCT  = OCT_W'(OCTAVES - 1);
    localparam logic [ACC_W-1:0]  SAT_MAX   = ACC_W'({AW{1'b1}});

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FILTER = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [NOTE_W-1:0]          note_q, note_d;
    logic [OCT_W-1:0]           oct_q, oct_d;
    logic                       flag_q, flag_d;
    logic [BIN_QTY-1:0][AW-1:0] note_amp_q;
    logic                       start_q;
    logic                       frame_sat_q;

    logic                       in_accum, in_filter, in_emit;
    logic                       accept, last_note, last_oct;
    logic [BIN_QTY-1:0][ACC_W-1:0] acc_vec;
    logic [BIN_QTY-1:0][AW-1:0]    emit_src;
    logic [ACC_W-1:0]           acc_sel;
    logic                       over_sel;
    logic [AW-1:0]              sat_sel;

    assign in_accum  = (state_q == ACCUM);
    assign in_filter = (state_q == FILTER);
    assign in_emit   = (state_q == EMIT);

    // Ready is masked by reset so every output reads 0 while rst is held.
    assign bin_ready_o = rst & in_accum;
    assign busy_o      = ~in_accum;
    assign accept      = bin_v_i & bin_ready_o;
    assign last_note   = (note_q == LAST_NOTE);
    assign last_oct    = (oct_q == LAST_OCT);

    // One clamp shared by all notes: FILTER walks the notes with note_q.
    assign acc_sel  = acc_vec[note_q];
    assign over_sel = (acc_sel > SAT_MAX);
    assign sat_sel  = over_sel ? {AW{1'b1}} : acc_sel[AW-1:0];

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        oct_d   = oct_q;
        flag_d  = flag_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (last_note) begin
                        note_d = '0;
                        if (last_oct) begin
                            oct_d   = '0;
                            state_d = FILTER;
                        end else begin
                            oct_d = oct_q + OCT_W'(1);
                        end
                    end else begin
                        note_d = note_q + NOTE_W'(1);
                    end
                end
            end
            FILTER: begin
                if (over_sel) begin
                    flag_d = 1'b1;
                end
                if (last_note) begin
                    note_d  = '0;
                    state_d = EMIT;
                end else begin
                    note_d = note_q + NOTE_W'(1);
                end
            end
            EMIT: begin
                flag_d  = 1'b0;
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
                note_d  = '0;
                oct_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCUM;
            note_q      <= '0;
            oct_q       <= '0;
            flag_q      <= 1'b0;
            note_amp_q  <= '0;
            start_q     <= 1'b0;
            frame_sat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_q      <= note_d;
            oct_q       <= oct_d;
            flag_q      <= flag_d;
            start_q     <= in_emit;
            frame_sat_q <= in_emit & flag_q;
            if (in_emit) begin
                note_amp_q <= emit_src;
            end
        end
    end

    assign noteAmplitudes_o = note_amp_q;
    assign start_o          = start_q;
    assign frame_sat_o      = frame_sat_q;

`ifdef NOTE_FOLD_IIR_EN
    logic [BIN_QTY-1:0][AW-1:0] y_vec;
    logic signed [AW:0]         iir_diff, iir_step, iir_sum;
    logic [AW-1:0]              y_next;

    // Signed W+D+1 bits holds sat-y exactly; the floored step keeps the
    // result inside [0, sat], so dropping the sign bit is lossless.
    assign iir_diff = $signed({1'b0, sat_sel}) - $signed({1'b0, y_vec[note_q]});
    assign iir_step = iir_diff >>> IIR_SHIFT;
    assign iir_sum  = $signed({1'b0, y_vec[note_q]}) + iir_step;
    assign y_next   = iir_sum[AW-1:0];
`endif

    for (genvar gi = 0; gi < BIN_QTY; gi++) begin : g_note
        logic [ACC_W-1:0] acc_q;
        logic             sel;

        assign sel = (note_q == NOTE_W'(gi));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc_q <= '0;
            end else if (accept && sel) begin
                // Octave 0 overwrites, so no clear pass is needed between frames.
                if (oct_q == '0) begin
                    acc_q <= ACC_W'(bin_i);
                end else begin
                    acc_q <= acc_q + ACC_W'(bin_i);
                end
            end
`ifndef NOTE_FOLD_IIR_EN
            // Without smoothing the accumulator itself holds the clamped
            // value until EMIT copies it out.
            else if (in_filter && sel) begin
                acc_q <= ACC_W'(sat_sel);
            end
`endif
        end

        assign acc_vec[gi] = acc_q;

`ifdef NOTE_FOLD_IIR_EN
        logic [AW-1:0] y_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                y_q <= '0;
            end else if (in_filter && sel) begin
                y_q <= y_next;
            end
        end

        assign y_vec[gi]    = y_q;
        assign emit_src[gi] = y_q;
`else
        assign emit_src[gi] = acc_q[AW-1:0];
`endif
    end

endmodule

// File: tb/tb_note_fold_smoother.sv
// -----------------------------------------------------------------------------
// tb_note_fold_smoother
//
// Directed bench for note_fold_smoother. The driver streams frames from a
// frame buffer; at each frame's last accept the expected note array, the
// saturation flag and the cycle of the start pulse are pushed to a scoreboard
// queue. A monitor pops an entry on every start_o and also checks busy/ready
// against the schedule implied by the last accepted bin.
// Expected values follow NOTE_FOLD_IIR_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_fold_smoother;
    localparam int W         = 5;
    localparam int D         = 11;
    localparam int BIN_QTY   = 12;
    localparam int OCTAVES   = 5;
    localparam int IIR_SHIFT = 2;
    localparam int AW        = W + D;
    localparam int NBINS     = BIN_QTY * OCTAVES;
    localparam int MAXV      = (1 << AW) - 1;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [AW-1:0]              bin_i = '0;
    logic                       bin_v_i = 1'b0;
    logic                       bin_ready_o;
    logic [BIN_QTY-1:0][AW-1:0] noteAmplitudes_o;
    logic                       start_o;
    logic                       frame_sat_o;
    logic                       busy_o;

    note_fold_smoother #(
        .W(W), .D(D), .BIN_QTY(BIN_QTY), .OCTAVES(OCTAVES), .IIR_SHIFT(IIR_SHIFT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bin_i            (bin_i),
        .bin_v_i          (bin_v_i),
        .bin_ready_o      (bin_ready_o),
        .noteAmplitudes_o (noteAmplitudes_o),
        .start_o          (start_o),
        .frame_sat_o      (frame_sat_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BIN_QTY-1:0][AW-1:0] notes;
        logic                       sat;
        logic [31:0]                cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            busy_from = -100;
    int            busy_to = -100;
    int            frames_sent = 0;
    logic [AW-1:0] fb[NBINS];
    int            y_model[BIN_QTY];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_now(input string why);
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", why, cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "stopping");
    endtask

    // Reference fold / clamp / optional IIR, computed in plain integers.
    task automatic push_expected(input int e_edge);
        exp_t e;
        int   sum, s, d, div;
        div   = 1 << IIR_SHIFT;
        e     = '0;
        for (int j = 0; j < BIN_QTY; j++) begin
            sum = 0;
            for (int o = 0; o < OCTAVES; o++) sum += int'(fb[o*BIN_QTY + j]);
            if (sum > MAXV) begin
                s     = MAXV;
                e.sat = 1'b1;
            end else begin
                s = sum;
            end
`ifdef NOTE_FOLD_IIR_EN
            d = s - y_model[j];
            if (d >= 0) d = d / div;
            else        d = -((-d + div - 1) / div);
            y_model[j] = y_model[j] + d;
            s = y_model[j];
`else
            d = div;
`endif
            e.notes[j] = AW'(s);
        end
        e.cyc = 32'(e_edge + BIN_QTY + 1);
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_bin(input logic [AW-1:0] v, output int e_edge);
        int waited;
        waited  = 0;
        bin_i   = v;
        bin_v_i = 1'b1;
        while (bin_ready_o !== 1'b1) begin
            if (waited >= 60) finish_now("accept_timeout");
            @(negedge clk);
            waited++;
        end
        e_edge = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send_frame(input bit hold);
        int e;
        e = 0;
        for (int n = 0; n < NBINS; n++) send_bin(fb[n], e);
        busy_from = e;
        busy_to   = e + BIN_QTY;
        push_expected(e);
        frames_sent++;
        if (!hold) bin_v_i = 1'b0;
    endtask

    // Monitor, sampling 1 time unit after each falling edge.
    initial begin
        logic prev_start;
        logic exp_busy;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
                check("busy_o", 32'(busy_o), 32'(exp_busy));
                check("bin_ready_o", 32'(bin_ready_o), 32'(!exp_busy));
            end
            if (start_o) begin
                check("start_single", 32'(prev_start), 32'd0);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_start: observed start_o=1 at cycle %0d expected no pulse", cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("frame start at cycle %0d: note0=%04h note11=%04h sat=%0d",
                             cyc, noteAmplitudes_o[0], noteAmplitudes_o[BIN_QTY-1], frame_sat_o);
                    for (int j = 0; j < BIN_QTY; j++)
                        check($sformatf("note[%0d]", j), 32'(noteAmplitudes_o[j]), 32'(e.notes[j]));
                    check("frame_sat_o", 32'(frame_sat_o), 32'(e.sat));
                    check("start_cycle", 32'(cyc), e.cyc);
                end
            end else begin
                check("frame_sat_idle", 32'(frame_sat_o), 32'd0);
            end
            prev_start = start_o;
        end
    end

    initial begin
        int e;
        for (int j = 0; j < BIN_QTY; j++) y_model[j] = 0;

        // Reset state, then release.
        repeat (2) @(negedge clk);
        #1;
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_ready", 32'(bin_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_notes_any", 32'(|noteAmplitudes_o), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("post_rst_ready", 32'(bin_ready_o), 32'd1);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);

        // Fold of constant 1.0 bins, three frames (repeated for the IIR case).
        for (int n = 0; n < NBINS; n++) fb[n] = 16'h0800;
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        send_frame(1'b0);
        send_frame(1'b0);

        // Full saturation: 5 x 8.0 = 40.0.
        for (int n = 0; n < NBINS; n++) fb[n] = 16'h4000;
        send_frame(1'b0);

        // Boundary: note 0 sums to exactly full scale (no clamp), mixed octaves.
        for (int n = 0; n < NBINS; n++) fb[n] = 16'h0100;
        for (int o = 0; o < OCTAVES; o++) begin
            fb[o*BIN_QTY + 0] = 16'h3333;
            fb[o*BIN_QTY + 2] = AW'(16 * (o + 1));
        end
        send_frame(1'b0);

        // Boundary: note 1 sums to full scale + 1 LSB (clamps, flag set).
        for (int o = 0; o < OCTAVES; o++) fb[o*BIN_QTY + 1] = (o == OCTAVES-1) ? 16'h3334 : 16'h3333;
        send_frame(1'b0);

        // Backpressure: valid held high through FILTER/EMIT, incrementing data.
        for (int n = 0; n < NBINS; n++) fb[n] = AW'(n * 16'h40 + 3);
        send_frame(1'b1);
        for (int n = 0; n < NBINS; n++) fb[n] = AW'(n * 16'h40 + 16'h15);
        send_frame(1'b0);
        repeat (20) @(negedge clk);

        // Mid-frame reset after 30 accepted bins.
        for (int n = 0; n < 30; n++) send_bin(16'h0123, e);
        bin_v_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int j = 0; j < BIN_QTY; j++)
            check($sformatf("midrst_note[%0d]", j), 32'(noteAmplitudes_o[j]), 32'd0);
        check("midrst_start", 32'(start_o), 32'd0);
        check("midrst_sat", 32'(frame_sat_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(bin_ready_o), 32'd0);
        busy_from = -100;
        busy_to   = -100;
        for (int j = 0; j < BIN_QTY; j++) y_model[j] = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rel_ready", 32'(bin_ready_o), 32'd1);
        check("midrst_rel_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        for (int n = 0; n < NBINS; n++) fb[n] = 16'h0800;
        send_frame(1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("frames sent: %0d", frames_sent);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
